// File: rtl/score_keeper.sv
// Single-player score keeper: synchronizes and debounces the hit button, then
// runs an IDLE/PLAY/WIN round FSM that counts hits and misses up to WIN_SCORE.
`timescale 1ns/1ps

module score_keeper #(
  parameter int DEBOUNCE_MS = 10,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1ms,
  input  logic       hit_btn,
  input  logic       miss,
  input  logic       start,
  output logic [4:0] player_score,
  output logic       win,
  output logic       playing
);

  localparam logic [4:0] DB_LAST = 5'(DEBOUNCE_MS - 1);
  localparam logic [4:0] WIN_VAL = 5'(WIN_SCORE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2
  } state_t;

  logic       btn_meta_p0;
  logic       btn_s;
  logic       btn_db;
  logic [4:0] db_cnt;
  logic       hit_evt;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] score_nxt;
  logic       win_nxt;
  logic       playing_nxt;

  function automatic logic [4:0] sat_inc(input logic [4:0] s);
    return (s >= WIN_VAL) ? WIN_VAL : s + 5'd1;
  endfunction

  function automatic logic [4:0] sat_dec(input logic [4:0] s);
    return (s == 5'd0) ? 5'd0 : s - 5'd1;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_meta_p0 <= 1'b0;
      btn_s       <= 1'b0;
    end else begin
      btn_meta_p0 <= hit_btn;
      btn_s       <= btn_meta_p0;
    end
  end

  // Debounce: a changed level must survive DEBOUNCE_MS ms ticks; hit_evt
  // is registered on the accepting edge so the score moves one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_db  <= 1'b0;
      db_cnt  <= 5'd0;
      hit_evt <= 1'b0;
    end else begin
      hit_evt <= 1'b0;
      if (btn_s == btn_db) begin
        db_cnt <= 5'd0;
      end else if (clk_1ms) begin
        if (db_cnt == DB_LAST) begin
          btn_db  <= btn_s;
          db_cnt  <= 5'd0;
          hit_evt <= btn_s;
        end else begin
          db_cnt <= db_cnt + 5'd1;
        end
      end
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      player_score <= 5'd0;
      win          <= 1'b0;
      playing      <= 1'b0;
    end else begin
      state        <= state_nxt;
      player_score <= score_nxt;
      win          <= win_nxt;
      playing      <= playing_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    score_nxt = player_score;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = PLAY;
          score_nxt = 5'd0;
        end
      end
      PLAY: begin
        if (start) begin
          score_nxt = 5'd0;
        end else if (hit_evt && !miss) begin
          score_nxt = sat_inc(player_score);
          if (sat_inc(player_score) == WIN_VAL) state_nxt = WIN;
        end else if (miss && !hit_evt) begin
          score_nxt = sat_dec(player_score);
        end
      end
      WIN: begin
        if (start) begin
          state_nxt = PLAY;
          score_nxt = 5'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        score_nxt = 5'd0;
      end
    endcase
  end

  // Outputs decode the next state so they change together with it
  always_comb begin
    win_nxt     = 1'b0;
    playing_nxt = 1'b0;
    unique case (state_nxt)
      PLAY:    playing_nxt = 1'b1;
      WIN:     win_nxt     = 1'b1;
      default: begin
        win_nxt     = 1'b0;
        playing_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: expected outputs are queued as each step
// is driven and popped for comparison once the clock edge has produced them.
`timescale 1ns/1ps

module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_1ms = 1'b0;
  logic       hit_btn = 1'b0;
  logic       miss = 1'b0;
  logic       start = 1'b0;
  logic [4:0] player_score;
  logic       win;
  logic       playing;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0] sc;
    logic       w;
    logic       p;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  score_keeper #(.DEBOUNCE_MS(10), .WIN_SCORE(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_1ms      (clk_1ms),
    .hit_btn      (hit_btn),
    .miss         (miss),
    .start        (start),
    .player_score (player_score),
    .win          (win),
    .playing      (playing)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic t, input logic s, input logic m);
    @(negedge clk);
    clk_1ms = t;
    start   = s;
    miss    = m;
    @(posedge clk);
    #1;
    clk_1ms = 1'b0;
    start   = 1'b0;
    miss    = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int sc, input logic w, input logic p);
    exp_t e;
    e.sc = 5'(sc);
    e.w  = w;
    e.p  = p;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    exp_t  o;
    string tag;
    e = exp_q.pop_front();
    tag = tag_q.pop_front();
    o.sc = player_score;
    o.w  = win;
    o.p  = playing;
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed score=%0d win=%b playing=%b, expected score=%0d win=%b playing=%b",
             tag, o.sc, o.w, o.p, e.sc, e.w, e.p);
    end
  endtask

  task automatic dchk(input string tag, input logic t, input logic s, input logic m,
                      input int sc, input logic w, input logic p);
    expect_out(tag, sc, w, p);
    drive(t, s, m);
    check_out();
  endtask

  task automatic now_chk(input string tag, input int sc, input logic w, input logic p);
    expect_out(tag, sc, w, p);
    check_out();
  endtask

  // Raise the button, let it synchronize, then deliver n ms ticks; the
  // last tick lands on the final edge of the task.
  task automatic press(input int n);
    hit_btn = 1'b1;
    drive(0, 0, 0);
    drive(0, 0, 0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        drive(0, 0, 0);
        drive(0, 0, 0);
      end
      drive(1, 0, 0);
    end
  endtask

  task automatic release_btn();
    hit_btn = 1'b0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0);
      drive(0, 0, 0);
      drive(0, 0, 0);
    end
  endtask

  task automatic hit(input string tag, input int sc, input logic w, input logic p);
    press(10);
    dchk(tag, 0, 0, 0, sc, w, p);
    release_btn();
  endtask

  initial begin
    // Reset held low for three edges
    for (int i = 0; i < 3; i++) dchk("reset_state", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    dchk("idle_hold", 0, 0, 0, 0, 0, 0);
    dchk("idle_miss_ignored", 0, 0, 1, 0, 0, 0);
    dchk("start_to_play", 0, 1, 0, 0, 0, 1);

    // Short press: 9 ticks is not enough
    press(9);
    dchk("glitch_9_ticks", 0, 0, 0, 0, 0, 1);
    hit_btn = 1'b0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0);
    now_chk("glitch_released", 0, 0, 1);

    // Full press: score moves one edge after acceptance, exactly once
    press(10);
    now_chk("hit_not_yet", 0, 0, 1);
    dchk("hit_first", 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0);
    now_chk("hit_once", 1, 0, 1);
    release_btn();
    now_chk("release_no_hit", 1, 0, 1);

    dchk("miss_dec", 0, 0, 1, 0, 0, 1);
    dchk("miss_sat_zero", 0, 0, 1, 0, 0, 1);

    hit("hit_to_1", 1, 0, 1);
    hit("hit_to_2", 2, 0, 1);
    hit("hit_to_3", 3, 0, 1);
    press(10);
    dchk("hit_and_miss", 0, 0, 1, 3, 0, 1);
    release_btn();
    dchk("miss_alone", 0, 0, 1, 2, 0, 1);

    hit("hit_to_3b", 3, 0, 1);
    hit("hit_to_4", 4, 0, 1);
    hit("hit_to_5", 5, 0, 1);
    press(10);
    dchk("start_beats_hit", 0, 1, 0, 0, 0, 1);
    release_btn();
    now_chk("start_beats_hit_after", 0, 0, 1);

    for (int k = 1; k <= 8; k++) hit("climb", k, 0, 1);
    hit("reach_win", 9, 1, 0);
    hit("win_hit_ignored", 9, 1, 0);
    dchk("win_miss_ignored", 0, 0, 1, 9, 1, 0);
    dchk("win_hold", 0, 0, 0, 9, 1, 0);
    dchk("win_start", 0, 1, 0, 0, 0, 1);

    // Mid-round, mid-debounce reset with the button still held
    for (int k = 1; k <= 4; k++) hit("climb_b", k, 0, 1);
    press(5);
    reset = 1'b0;
    dchk("reset_mid_round", 0, 0, 0, 0, 0, 0);
    dchk("reset_mid_round_2", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    dchk("post_reset_idle", 0, 0, 1, 0, 0, 0);
    dchk("post_reset_start", 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        drive(0, 0, 0);
        drive(0, 0, 0);
      end
      if (i == 9) now_chk("no_early_hit", 0, 0, 1);
      drive(1, 0, 0);
    end
    dchk("fresh_debounce_hit", 0, 0, 0, 1, 0, 1);
    release_btn();
    now_chk("final_state", 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
